// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and the datapath select/ALU-op codes driven by the controller.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWRITE = 4'd5,
    S_MEMWB    = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_JAL      = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Only beq (000) and bne (001) are implemented by the branch step.
  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3[2:1] == 2'b00);
  endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format select, purely from the opcode; valid in every state.
module imm_src_dec
  import core_ctrl_pkg::*;
(
  input  logic [6:0] Op,
  output logic [2:0] Imm_Src
);

  // Opcode -> immediate format; unknown opcodes fall back to I-type.
  always_comb begin
    Imm_Src = IMM_I;
    case (Op)
      OP_STORE:          Imm_Src = IMM_S;
      OP_BRANCH:         Imm_Src = IMM_B;
      OP_JAL:            Imm_Src = IMM_J;
      OP_LUI, OP_AUIPC:  Imm_Src = IMM_U;
      default:           Imm_Src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core. Moore decode of datapath
// selects from the state register; PC/IR/memory strobes additionally
// qualified by Mem_Ready and the ALU zero flag.
module multicycle_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter logic RESET_TO_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       Adr_Src,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic [1:0] Result_Src,
  output logic [1:0] Alu_Src_A,
  output logic [1:0] Alu_Src_B,
  output logic [1:0] Alu_Op,
  output logic [2:0] Imm_Src,
  output logic       Reg_Write,
  output logic       Illegal_Instr,
  output logic       Instr_Retired
);

  state_t     state, state_nxt;
  logic       pc_update, branch, ir_write_d, mem_write_d, reg_write_d;
  logic       adr_src_d, illegal_d, retired_d;
  logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d, alu_op_d;

  imm_src_dec u_imm_src_dec (
    .Op      (Op),
    .Imm_Src (Imm_Src)
  );

  // State register; reset may land mid-access, the access is simply abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_TO_IDLE ? S_IDLE : S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and Moore output decode; every output defaults to 0.
  always_comb begin
    state_nxt    = state;
    pc_update    = 1'b0;
    branch       = 1'b0;
    ir_write_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    adr_src_d    = 1'b0;
    illegal_d    = 1'b0;
    retired_d    = 1'b0;
    result_src_d = RES_ALUOUT;
    alu_src_a_d  = SRCA_PC;
    alu_src_b_d  = SRCB_RD2;
    alu_op_d     = ALU_ADD;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        alu_src_a_d  = SRCA_PC;
        alu_src_b_d  = SRCB_FOUR;
        result_src_d = RES_ALURES;
        ir_write_d   = Mem_Ready;
        pc_update    = Mem_Ready;
        state_nxt    = Mem_Ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALUOut <= OldPC + Imm, consumed later by branch/jal/auipc
        alu_src_a_d = SRCA_OLDPC;
        alu_src_b_d = SRCB_IMM;
        case (Op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_ALUWB;
          OP_BRANCH: begin
            if (branch_f3_ok(Funct3)) state_nxt = S_BRANCH;
            else begin
              illegal_d = 1'b1;
              state_nxt = S_FETCH;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_d = SRCA_RD1;
        alu_src_b_d = SRCB_IMM;
        state_nxt   = Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_d = 1'b1;
        state_nxt = Mem_Ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        adr_src_d   = 1'b1;
        mem_write_d = 1'b1;
        retired_d   = Mem_Ready;
        state_nxt   = Mem_Ready ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        result_src_d = RES_RDATA;
        reg_write_d  = 1'b1;
        retired_d    = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_d = SRCA_RD1;
        alu_src_b_d = SRCB_RD2;
        alu_op_d    = ALU_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_d = SRCA_RD1;
        alu_src_b_d = SRCB_IMM;
        alu_op_d    = ALU_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_d = RES_ALUOUT;
        reg_write_d  = 1'b1;
        retired_d    = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_d  = SRCA_RD1;
        alu_src_b_d  = SRCB_RD2;
        alu_op_d     = ALU_SUB;
        result_src_d = RES_ALUOUT;
        branch       = 1'b1;
        retired_d    = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a_d = SRCA_RD1;
        alu_src_b_d = SRCB_IMM;
        state_nxt   = S_JAL;
      end
      S_JAL: begin
        // PC <= ALUOut (target) while ALU forms OldPC+4 for the link write
        alu_src_a_d  = SRCA_OLDPC;
        alu_src_b_d  = SRCB_FOUR;
        result_src_d = RES_ALUOUT;
        pc_update    = 1'b1;
        state_nxt    = S_ALUWB;
      end
      S_LUI: begin
        result_src_d = RES_IMM;
        reg_write_d  = 1'b1;
        retired_d    = 1'b1;
        state_nxt    = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Outputs forced quiet while reset is asserted, whatever the reset state.
  assign PC_Write      = rst_n & (pc_update | (branch & (Zero ^ Funct3[0])));
  assign Adr_Src       = rst_n & adr_src_d;
  assign Mem_Write     = rst_n & mem_write_d;
  assign IR_Write      = rst_n & ir_write_d;
  assign Reg_Write     = rst_n & reg_write_d;
  assign Illegal_Instr = rst_n & illegal_d;
  assign Instr_Retired = rst_n & retired_d;
  assign Result_Src    = rst_n ? result_src_d : 2'b00;
  assign Alu_Src_A     = rst_n ? alu_src_a_d  : 2'b00;
  assign Alu_Src_B     = rst_n ? alu_src_b_d  : 2'b00;
  assign Alu_Op        = rst_n ? alu_op_d     : 2'b00;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: each instruction is expanded by a small
// instruction-level model into a per-cycle list of expected outputs plus the
// Mem_Ready value to drive; one loop drives and compares every cycle.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Zero, Mem_Ready;
  logic       PC_Write, Adr_Src, Mem_Write, IR_Write, Reg_Write, Illegal_Instr, Instr_Retired;
  logic [1:0] Result_Src, Alu_Src_A, Alu_Src_B, Alu_Op;
  logic [2:0] Imm_Src;
  logic [14:0] got;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.RESET_TO_IDLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct3(Funct3), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .Adr_Src(Adr_Src), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Result_Src(Result_Src), .Alu_Src_A(Alu_Src_A), .Alu_Src_B(Alu_Src_B), .Alu_Op(Alu_Op),
    .Imm_Src(Imm_Src), .Reg_Write(Reg_Write), .Illegal_Instr(Illegal_Instr),
    .Instr_Retired(Instr_Retired)
  );

  assign got = {PC_Write, Adr_Src, Mem_Write, IR_Write, Result_Src, Alu_Src_A, Alu_Src_B,
                Alu_Op, Reg_Write, Illegal_Instr, Instr_Retired};

  typedef struct { logic mr; logic [14:0] exp; } step_t;
  step_t q[$];
  int checks = 0, errors = 0;
  int retire_seen = 0, last_ret = 0, ill_seen = 0;

  function automatic logic [14:0] ov(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                                     aop, input logic rw, ill, ret);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, ill, ret};
  endfunction

  function automatic logic [2:0] imm_model(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, g, e);
    end
  endtask

  task automatic push(input logic mr, input logic [14:0] e);
    step_t s;
    s.mr = mr; s.exp = e;
    q.push_back(s);
  endtask

  task automatic push_aluwb();
    push(1'b1, ov(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,1));
  endtask

  // Expected cycle-by-cycle behaviour of one instruction.
  // fw: fetch wait cycles, mw: memory wait cycles in the load/store access.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                       input int fw, input int mw);
    logic legal;
    for (int i = 0; i < fw; i++) push(1'b0, ov(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0));
    push(1'b1, ov(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,0,0));
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: legal = 1'b1;
      7'b1100011: legal = (f3 == 3'b000) || (f3 == 3'b001);
      default:    legal = 1'b0;
    endcase
    push(1'b1, ov(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,!legal,0));
    if (legal) begin
      case (op)
        7'b0000011: begin
          push(1'b1, ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0));
          for (int i = 0; i < mw; i++) push(1'b0, ov(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0));
          push(1'b1, ov(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0));
          push(1'b1, ov(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,0,1));
        end
        7'b0100011: begin
          push(1'b1, ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0));
          for (int i = 0; i < mw; i++) push(1'b0, ov(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0));
          push(1'b1, ov(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,1));
        end
        7'b0110011: begin
          push(1'b1, ov(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,0));
          push_aluwb();
        end
        7'b0010011: begin
          push(1'b1, ov(0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0,0));
          push_aluwb();
        end
        7'b1100011: push(1'b1, ov(zero ^ f3[0],0,0,0,2'b00,2'b10,2'b00,2'b01,0,0,1));
        7'b1100111, 7'b1101111: begin
          if (op == 7'b1100111) push(1'b1, ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0));
          push(1'b1, ov(1,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0));
          push_aluwb();
        end
        7'b0110111: push(1'b1, ov(0,0,0,0,2'b11,2'b00,2'b00,2'b00,1,0,1));
        default: push_aluwb();
      endcase
    end
  endtask

  // Drive and compare every queued cycle; records the cycle of retirement.
  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic zero);
    last_ret = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      Op = op; Funct3 = f3; Zero = zero; Mem_Ready = q[i].mr;
      #1;
      chk($sformatf("%s_c%0d", nm, i + 1), {17'd0, got}, {17'd0, q[i].exp});
      chk($sformatf("%s_imm_c%0d", nm, i + 1), {29'd0, Imm_Src}, {29'd0, imm_model(op)});
      if (Instr_Retired) begin retire_seen++; last_ret = i + 1; end
      if (Illegal_Instr) ill_seen++;
    end
    q.delete();
  endtask

  task automatic instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic zero, input int fw, input int mw, input int exp_ret);
    build(op, f3, zero, fw, mw);
    run(nm, op, f3, zero);
    chk({nm, "_retire_cycle"}, last_ret, exp_ret);
  endtask

  task automatic check_quiet(input string nm);
    chk(nm, {17'd0, got}, 32'd0);
    chk({nm, "_imm"}, {29'd0, Imm_Src}, {29'd0, imm_model(Op)});
  endtask

  initial begin
    rst_n = 1'b0; Op = 7'b0110011; Funct3 = 3'b000; Zero = 1'b0; Mem_Ready = 1'b0;
    @(negedge clk); #1 check_quiet("reset_a");
    @(negedge clk); #1 check_quiet("reset_b");
    @(negedge clk); rst_n = 1'b1; Mem_Ready = 1'b1;
    #1 check_quiet("idle_after_reset");

    instr("add",   7'b0110011, 3'b000, 1'b0, 0, 0, 4);
    build(7'b0000011, 3'b010, 1'b0, 0, 3);
    chk("lw_model_len", q.size(), 8);
    run("lw", 7'b0000011, 3'b010, 1'b0);
    chk("lw_retire_cycle", last_ret, 8);
    instr("sw",    7'b0100011, 3'b010, 1'b0, 1, 1, 6);
    instr("beq_t", 7'b1100011, 3'b000, 1'b1, 0, 0, 3);
    instr("bne_n", 7'b1100011, 3'b001, 1'b1, 0, 0, 3);
    instr("beq_n", 7'b1100011, 3'b000, 1'b0, 0, 0, 3);
    instr("bne_t", 7'b1100011, 3'b001, 1'b0, 0, 0, 3);
    instr("jalr",  7'b1100111, 3'b000, 1'b0, 0, 0, 5);
    instr("jal",   7'b1101111, 3'b000, 1'b0, 0, 0, 4);
    instr("lui",   7'b0110111, 3'b000, 1'b0, 0, 0, 3);
    instr("addi",  7'b0010011, 3'b000, 1'b0, 2, 0, 6);
    instr("ill_op", 7'b1111111, 3'b000, 1'b0, 0, 0, 0);
    instr("ill_br", 7'b1100011, 3'b100, 1'b1, 0, 0, 0);
    chk("illegal_pulses", ill_seen, 2);

    // Reset while a load is waiting in the memory-read step.
    build(7'b0000011, 3'b010, 1'b0, 0, 4);
    while (q.size() > 5) void'(q.pop_back());
    run("lw_cut", 7'b0000011, 3'b010, 1'b0);
    @(negedge clk); Mem_Ready = 1'b0; #2 rst_n = 1'b0;
    #1 check_quiet("reset_mid_memread");
    @(negedge clk); #1 check_quiet("reset_mid_hold");
    @(negedge clk); rst_n = 1'b1; Mem_Ready = 1'b1;
    #1 check_quiet("idle_after_mid_reset");
    instr("add2",  7'b0110011, 3'b000, 1'b0, 0, 0, 4);

    chk("retire_total", retire_seen, 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
